// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, receiver state encoding and parity helper
package ps2_pkg;

    localparam int DATA_BITS = 8;
    localparam logic [7:0] F0_BREAK = 8'hF0;
    localparam logic [7:0] E0_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic p);
        return ^{data, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser plus glitch filter for one asynchronous PS/2 line
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign dout     = r_dout;

    // The filtered line only moves after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_dout <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            if (w_synced == r_dout) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_dout <= w_synced;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 device-to-host frame receiver producing 8-bit scan codes
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] Keyboard_Data,
    output logic       ready_pulse,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 w_filt_clk;
    logic                 w_filt_data;
    logic                 r_filt_clk_q;
    logic                 w_fall;
    ps2_state_t           r_state;
    ps2_state_t           w_state_nxt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 w_timeout;
    logic                 w_good;
    logic                 w_perr;
    logic                 w_ferr;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk),
        .dout  (w_filt_clk)
    );

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_data),
        .dout  (w_filt_data)
    );

    assign w_fall    = r_filt_clk_q & ~w_filt_clk;
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !w_filt_data) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fall && (r_bit_cnt == BIT_LAST)) begin
                    w_state_nxt = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // A bad stop bit is reported as a framing error even if parity also failed
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    if (!w_filt_data) begin
                        w_ferr = 1'b1;
                    end else if (odd_parity_ok(r_shift, r_parity)) begin
                        w_good = 1'b1;
                    end else begin
                        w_perr = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_timeout && !w_fall) begin
            w_state_nxt = ST_IDLE;
            w_ferr      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_clk_q  <= 1'b1;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_to_cnt      <= '0;
            Keyboard_Data <= 8'h00;
            ready_pulse   <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            r_filt_clk_q <= w_filt_clk;
            ready_pulse  <= w_good;
            parity_err   <= w_perr;
            frame_err    <= w_ferr;
            if (w_good) begin
                Keyboard_Data <= r_shift;
            end

            if ((r_state == ST_IDLE) || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        r_shift[r_bit_cnt] <= w_filt_data;
                        if (r_bit_cnt != BIT_LAST) begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= w_filt_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - scoreboard bench for ps2_receiver: framing, errors, timeout, glitches, reset
module tb_ps2_receiver;

    localparam int SYNC = 2;
    localparam int FILT = 8;
    localparam int TO   = 200;
    localparam int HALF = 40;
    localparam int K_GOOD = 0;
    localparam int K_PERR = 1;
    localparam int K_FERR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] kd;
    logic       rp;
    logic       pe;
    logic       fe;

    always #5 clk = ~clk;

    ps2_receiver #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .Keyboard_Data (kd),
        .ready_pulse   (rp),
        .parity_err    (pe),
        .frame_err     (fe)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_evt_cyc = 0;
    int   last_fall_cyc = 0;
    int   n_ready_cyc = 0;
    logic prev_rp = 1'b0;
    exp_t m_e;
    logic [2:0] m_exp_flags;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rp === 1'b1) begin
            n_ready_cyc++;
            if (prev_rp === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL pulse_width: ready_pulse high 2+ cycles at cyc %0d, required 1", cyc);
            end
        end
        if ((rp | pe | fe) === 1'b1) begin
            last_evt_cyc = cyc;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: flags rp/pe/fe=%b data=%h, required no event", {rp, pe, fe}, kd);
            end else begin
                m_e = exp_q.pop_front();
                m_exp_flags = (m_e.kind == K_GOOD) ? 3'b100 : ((m_e.kind == K_PERR) ? 3'b010 : 3'b001);
                if (({rp, pe, fe} !== m_exp_flags) || ((m_e.kind == K_GOOD) && (kd !== m_e.data))) begin
                    n_err++;
                    $display("FAIL event: flags=%b data=%h, required flags=%b data=%h",
                             {rp, pe, fe}, kd, m_exp_flags, m_e.data);
                end
            end
        end
        prev_rp = rp;
    end

    task automatic push_exp(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 13) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip_par, input logic stop,
                              input int nfalls, input bit glitch);
        logic [10:0] bits;
        logic        par;
        par  = (~^d) ^ flip_par;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nfalls; i++) ps2_bit(bits[i], glitch);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_kd(input string name, input logic [7:0] want);
        n_vec++;
        if (kd !== want) begin
            n_err++;
            $display("FAIL %s: Keyboard_Data=%h, required %h", name, kd, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (kd !== 8'h00) begin n_err++; $display("FAIL reset_kd: %h, required 00", kd); end
        n_vec++; if (rp !== 1'b0) begin n_err++; $display("FAIL reset_rp: %b, required 0", rp); end
        n_vec++; if (pe !== 1'b0) begin n_err++; $display("FAIL reset_pe: %b, required 0", pe); end
        n_vec++; if (fe !== 1'b0) begin n_err++; $display("FAIL reset_fe: %b, required 0", fe); end
        reset = 1'b0;
        repeat (50) @(negedge clk);
        n_vec++;
        if ({kd, rp, pe, fe} !== 11'd0) begin
            n_err++;
            $display("FAIL idle_after_reset: kd=%h flags=%b, required 00/000", kd, {rp, pe, fe});
        end
    endtask

    task automatic test_single();
        int n0;
        int lat;
        n0 = n_ready_cyc;
        push_exp(K_GOOD, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_drain(100);
        check_kd("single_data", 8'h1C);
        lat = last_evt_cyc - last_fall_cyc;
        n_vec++;
        if (lat != SYNC + FILT + 1) begin
            n_err++;
            $display("FAIL single_latency: %0d cycles, required %0d", lat, SYNC + FILT + 1);
        end
        n_vec++;
        if (n_ready_cyc - n0 != 1) begin
            n_err++;
            $display("FAIL single_pulse_count: %0d cycles high, required 1", n_ready_cyc - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = n_ready_cyc;
        push_exp(K_GOOD, 8'hF0);
        push_exp(K_GOOD, 8'h1C);
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_drain(100);
        check_kd("b2b_data", 8'h1C);
        n_vec++;
        if (n_ready_cyc - n0 != 2) begin
            n_err++;
            $display("FAIL b2b_pulse_count: %0d, required 2", n_ready_cyc - n0);
        end
    endtask

    task automatic test_parity_error();
        int n0;
        n0 = n_ready_cyc;
        push_exp(K_PERR, 8'h00);
        send_frame(8'h29, 1'b1, 1'b1, 11, 1'b0);
        wait_drain(100);
        check_kd("parity_hold", 8'h1C);
        n_vec++;
        if (n_ready_cyc != n0) begin
            n_err++;
            $display("FAIL parity_no_ready: %0d pulses, required 0", n_ready_cyc - n0);
        end
    endtask

    task automatic test_stop_error();
        push_exp(K_FERR, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b0);
        wait_drain(100);
        check_kd("stop_err_hold", 8'h1C);
        push_exp(K_GOOD, 8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
        wait_drain(100);
        check_kd("stop_err_recover", 8'h5A);
    endtask

    task automatic test_timeout();
        int lat;
        push_exp(K_FERR, 8'h00);
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
        wait_drain(TO + 100);
        lat = last_evt_cyc - last_fall_cyc;
        n_vec++;
        if (lat < SYNC + FILT + 1 + TO || lat > SYNC + FILT + 3 + TO) begin
            n_err++;
            $display("FAIL timeout_latency: %0d cycles, required %0d..%0d",
                     lat, SYNC + FILT + 1 + TO, SYNC + FILT + 3 + TO);
        end
        check_kd("timeout_hold", 8'h5A);
        push_exp(K_GOOD, 8'h16);
        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
        wait_drain(100);
        check_kd("timeout_recover", 8'h16);
    endtask

    task automatic test_glitch_reset();
        int n0;
        push_exp(K_GOOD, 8'h32);
        send_frame(8'h32, 1'b0, 1'b1, 11, 1'b1);
        wait_drain(100);
        check_kd("glitch_data", 8'h32);
        send_frame(8'h7E, 1'b0, 1'b1, 6, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_kd("midframe_reset_kd", 8'h00);
        n_vec++;
        if ({rp, pe, fe} !== 3'b000) begin
            n_err++;
            $display("FAIL midframe_reset_flags: %b, required 000", {rp, pe, fe});
        end
        reset = 1'b0;
        n0 = n_ready_cyc;
        repeat (TO + 50) @(negedge clk);
        check_kd("post_reset_kd", 8'h00);
        n_vec++;
        if (n_ready_cyc != n0) begin
            n_err++;
            $display("FAIL post_reset_spurious: %0d pulses, required 0", n_ready_cyc - n0);
        end
        push_exp(K_GOOD, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_drain(100);
        check_kd("post_reset_recover", 8'h1C);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_glitch_reset();
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
